gpio_serial_loader: RTL and testbench
=====================================

Name: gpio_serial_loader

Overview:
- Management-side controller that serially configures the user-area GPIO pad control blocks (mprj_io[NUM_IO-1:0]) through the daisy-chained shift-register interface: serial clock, serial data, load strobe.
- Holds one CFG_BITS-wide configuration word per pad in a local register file, written and read by firmware over a simple register port.
- On a start pulse it streams the whole chain at a divided clock rate, then pulses load so every pad adopts its new mode (mgmt input/output, user bidirectional, pull-up/down, ...) at the same time.

Parameters:
- NUM_IO, 38, number of pad control blocks in the chain
- CFG_BITS, 13, configuration bits per pad
- CLK_DIV, 4, system clocks per serial bit; even, >= 2
- CFG_DEFAULT, 13'h0403, reset value of every config word

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- cfg_we  in  1  write strobe for config register file
- cfg_addr  in  6  pad index
- cfg_wdata  in  CFG_BITS  write data
- cfg_rdata  out  CFG_BITS  read data, combinational from cfg_addr
- start  in  1  one-cycle request to stream the chain
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the load strobe completes
- serial_clock  out  1  chain shift clock
- serial_data_out  out  1  chain data
- serial_load  out  1  chain parallel-load strobe
- serial_resetn  out  1  chain reset, active-low

Behaviour:
- Reset: all config words = CFG_DEFAULT; busy=0, done=0, serial_clock=0, serial_data_out=0, serial_load=0, serial_resetn=0. serial_resetn goes to 1 on the first clock after reset deasserts. All serial outputs are registered.
- Register port: a write with cfg_addr < NUM_IO and busy=0 updates the word. Writes while busy=1 or with cfg_addr >= NUM_IO are ignored. cfg_rdata returns 0 for cfg_addr >= NUM_IO.
- FSM states: IDLE, SHIFT, LOAD, DONE.
- IDLE:
  - start=1 sampled at edge N → SHIFT at N+1, with busy=1 and the first bit on serial_data_out.
  - start while busy is ignored; it is not queued.
- SHIFT:
  - Bit order: pad NUM_IO-1 first, down to pad 0; within each word MSB first.
  - Each bit occupies exactly CLK_DIV cycles. serial_clock=0 for the first CLK_DIV/2 cycles and 1 for the last CLK_DIV/2. Data changes only at the start of a bit period, so it is stable across the rising edge.
  - Counters: divider (0..CLK_DIV-1), bit index (CFG_BITS-1..0), pad index (NUM_IO-1..0). Each counter wraps and decrements the next.
  - After the final bit period (pad 0, bit 0) → LOAD. Total SHIFT duration is NUM_IO*CFG_BITS*CLK_DIV cycles, with exactly NUM_IO*CFG_BITS serial_clock rising edges.
- LOAD: serial_clock=0, serial_data_out=0, serial_load=1 for CLK_DIV cycles → DONE.
- DONE: serial_load=0, done=1 for one cycle, busy stays 1 this cycle. → IDLE, where busy=0.
- Data snapshot: words are read live during SHIFT. This is safe because writes are blocked while busy.
- Simultaneous start and cfg_we in IDLE: the write lands, and the stream uses the new value, since the first bit is taken from the updated word.
- Reset mid-operation: immediate return to IDLE with reset values. serial_resetn=0 clears the chain. Config words revert to CFG_DEFAULT.
- No backpressure or abort input; the only way to cancel a transfer is reset.

Test Plan:
- Reset check: after reset, cfg_rdata at every address = 13'h0403; busy=0, serial_load=0, serial_resetn=0. One cycle after reset drops, serial_resetn=1.
- Full load, defaults: write pad 37=13'h1ABC, pad 0=13'h0001, others default; pulse start.
  - A 494-bit shift-register model clocked on serial_clock rising edges and latched on serial_load holds the expected words (pad 0 slot = 0x0001, pad 37 slot = 0x1ABC).
  - busy is high for exactly 38*13*4 + 4 + 1 = 1981 cycles.
  - done pulses once.
- Timing: serial_data_out never changes in the cycle before or at a serial_clock rising edge. serial_load is never high while serial_clock=1. Repeat with CLK_DIV=2, which gives 988+3 busy cycles.
- Blocked accesses:
  - A write to pad 5 during SHIFT leaves cfg_rdata(5) unchanged.
  - start pulsed mid-SHIFT produces no second transfer (single done).
  - A write to addr 40 is ignored and reads 0.
- Reset mid-shift: assert reset at bit 200.
  - Next cycle: busy=0, serial_clock=0, serial_resetn=0, words = default.
  - A fresh start afterwards completes normally.
- Start with same-cycle write: cfg_we to pad 37 = 13'h1FFF together with start. The first 13 bits streamed are all 1.

Source files
------------

// File: rtl/gpio_serial_loader.sv
// Config register file for the user-area GPIO pads plus the streamer that shifts
// every word down the pad daisy chain at a divided rate and then strobes load.
module gpio_serial_loader #(
  parameter int unsigned         NUM_IO      = 38,
  parameter int unsigned         CFG_BITS    = 13,
  parameter int unsigned         CLK_DIV     = 4,
  parameter logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h0403
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [5:0]          cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_wdata,
  output logic [CFG_BITS-1:0] cfg_rdata,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_data_out,
  output logic                serial_load,
  output logic                serial_resetn
);

  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = (CFG_BITS > 2) ? $clog2(CFG_BITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
  localparam logic [5:0]    PAD_LAST = 6'(NUM_IO - 1);
  localparam logic [6:0]    NUM_IO_W = 7'(NUM_IO);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [DW-1:0]       r_div;
  logic [BW-1:0]       r_bit;
  logic [5:0]          r_pad;
  logic [CFG_BITS-1:0] r_cfg [NUM_IO];
  logic                r_busy;
  logic                r_done;
  logic                r_sclk;
  logic                r_sdo;
  logic                r_load;
  logic                r_resetn;

  state_t              w_nxt_state;
  logic [DW-1:0]       w_nxt_div;
  logic [BW-1:0]       w_nxt_bit;
  logic [5:0]          w_nxt_pad;
  logic                w_addr_ok;
  logic                w_wr_en;
  logic [CFG_BITS-1:0] w_word;
  logic                w_busy_d;
  logic                w_done_d;
  logic                w_load_d;
  logic                w_sclk_d;
  logic                w_sdo_d;

  assign w_addr_ok = ({1'b0, cfg_addr} < NUM_IO_W);
  assign w_wr_en   = cfg_we && w_addr_ok && (r_state == S_IDLE);
  // Bypass the write port so a word written in the start cycle streams its new value.
  assign w_word    = (w_wr_en && (cfg_addr == w_nxt_pad)) ? cfg_wdata : r_cfg[w_nxt_pad];

  // Firmware-visible config words; only writable while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_IO); i++) begin
        r_cfg[i] <= CFG_DEFAULT;
      end
    end else if (w_wr_en) begin
      r_cfg[cfg_addr] <= cfg_wdata;
    end
  end

  always_comb begin
    if (w_addr_ok) begin
      cfg_rdata = r_cfg[cfg_addr];
    end else begin
      cfg_rdata = {CFG_BITS{1'b0}};
    end
  end

  // State, counters and registered serial outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bit    <= BIT_LAST;
      r_pad    <= PAD_LAST;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sclk   <= 1'b0;
      r_sdo    <= 1'b0;
      r_load   <= 1'b0;
      r_resetn <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_div    <= w_nxt_div;
      r_bit    <= w_nxt_bit;
      r_pad    <= w_nxt_pad;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
      r_sclk   <= w_sclk_d;
      r_sdo    <= w_sdo_d;
      r_load   <= w_load_d;
      r_resetn <= 1'b1;
    end
  end

  // Divider wraps into bit index, bit index wraps into pad index; LOAD reuses the divider.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_div   = r_div;
    w_nxt_bit   = r_bit;
    w_nxt_pad   = r_pad;
    case (r_state)
      S_IDLE: begin
        w_nxt_div = '0;
        w_nxt_bit = BIT_LAST;
        w_nxt_pad = PAD_LAST;
        if (start) begin
          w_nxt_state = S_SHIFT;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_div != DIV_LAST) begin
          w_nxt_div = r_div + 1'b1;
        end else begin
          w_nxt_div = '0;
          if (r_bit != '0) begin
            w_nxt_bit = r_bit - 1'b1;
          end else begin
            w_nxt_bit = BIT_LAST;
            if (r_pad != 6'd0) begin
              w_nxt_pad = r_pad - 1'b1;
            end else begin
              w_nxt_pad   = PAD_LAST;
              w_nxt_state = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        if (r_div != DIV_LAST) begin
          w_nxt_div = r_div + 1'b1;
        end else begin
          w_nxt_div   = '0;
          w_nxt_state = S_DONE;
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state and counters.
  always_comb begin
    w_busy_d = (w_nxt_state != S_IDLE);
    w_done_d = (w_nxt_state == S_DONE);
    w_load_d = (w_nxt_state == S_LOAD);
    if (w_nxt_state == S_SHIFT) begin
      w_sclk_d = (w_nxt_div >= DIV_HALF);
      w_sdo_d  = w_word[w_nxt_bit];
    end else begin
      w_sclk_d = 1'b0;
      w_sdo_d  = 1'b0;
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign serial_clock    = r_sclk;
  assign serial_data_out = r_sdo;
  assign serial_load     = r_load;
  assign serial_resetn   = r_resetn;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: two instances (CLK_DIV 4 and 2) share stimulus;
// each has a pad-chain shift-register model clocked by its serial outputs.
module tb_gpio_serial_loader;

  localparam int NUM_IO   = 38;
  localparam int CFG_BITS = 13;
  localparam int TOTAL    = NUM_IO * CFG_BITS;
  localparam logic [12:0] DEF = 13'h0403;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cfg_addr = 6'd0;
  logic [12:0] cfg_wdata = 13'd0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [12:0] model [NUM_IO];
  int          base_busy [2];
  int          base_done [2];
  int          base_rise [2];

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int CD = (g == 0) ? 4 : 2;
    logic [12:0] rdata;
    logic busy, done, sclk, sdo, sload, srstn;

    gpio_serial_loader #(
      .NUM_IO(NUM_IO), .CFG_BITS(CFG_BITS), .CLK_DIV(CD), .CFG_DEFAULT(DEF)
    ) dut (
      .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_rdata(rdata), .start(start), .busy(busy),
      .done(done), .serial_clock(sclk), .serial_data_out(sdo),
      .serial_load(sload), .serial_resetn(srstn)
    );

    logic [TOTAL-1:0] sr = '0;
    logic [TOTAL-1:0] latched = '0;
    logic prev_sclk = 1'b0;
    logic prev_sdo = 1'b0;
    logic prev_load = 1'b0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int rise_cnt = 0;
    int viol_cnt = 0;

    // Pad chain: first bit shifted in ends up furthest along (pad NUM_IO-1 slot at the top).
    always @(negedge clock) begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (sclk && !prev_sclk) begin
        rise_cnt <= rise_cnt + 1;
        sr <= {sr[TOTAL-2:0], sdo};
        if (sdo !== prev_sdo) viol_cnt <= viol_cnt + 1;
      end
      if (sload && sclk) viol_cnt <= viol_cnt + 1;
      if (sload && !prev_load) latched <= sr;
      prev_sclk <= sclk;
      prev_sdo  <= sdo;
      prev_load <= sload;
    end
  end

  task automatic snap();
    base_busy[0] = gen_dut[0].busy_cnt;
    base_busy[1] = gen_dut[1].busy_cnt;
    base_done[0] = gen_dut[0].done_cnt;
    base_done[1] = gen_dut[1].done_cnt;
    base_rise[0] = gen_dut[0].rise_cnt;
    base_rise[1] = gen_dut[1].rise_cnt;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [12:0] d, input bit accept);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    if (accept) model[a] = d;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [5:0] a);
    logic [12:0] exp;
    cfg_addr = a;
    #1;
    exp = (a < NUM_IO) ? model[a] : 13'd0;
    check_eq($sformatf("%s_u0_a%0d", tag, a), gen_dut[0].rdata, exp);
    check_eq($sformatf("%s_u1_a%0d", tag, a), gen_dut[1].rdata, exp);
  endtask

  task automatic xfer_begin(input bit we, input logic [5:0] a, input logic [12:0] d);
    snap();
    start = 1'b1;
    cfg_we = we;
    cfg_addr = a;
    cfg_wdata = d;
    if (we && a < NUM_IO) model[a] = d;
    @(negedge clock);
    start = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic check_inst(input string tag, input int g, input int busy_d, input int done_d,
                            input int rise_d, input int viol, input logic busy_now,
                            input logic [TOTAL-1:0] lat);
    int cd;
    cd = (g == 0) ? 4 : 2;
    check_eq($sformatf("%s_u%0d_busy_cycles", tag, g), busy_d, TOTAL * cd + cd + 1);
    check_eq($sformatf("%s_u%0d_done_pulses", tag, g), done_d, 1);
    check_eq($sformatf("%s_u%0d_sclk_rises", tag, g), rise_d, TOTAL);
    check_eq($sformatf("%s_u%0d_timing_viol", tag, g), viol, 0);
    check_eq($sformatf("%s_u%0d_idle_after", tag, g), busy_now, 1'b0);
    for (int k = 0; k < NUM_IO; k++) begin
      check_eq($sformatf("%s_u%0d_pad%0d", tag, g, k), lat[k*CFG_BITS +: CFG_BITS], model[k]);
    end
  endtask

  task automatic xfer_end(input string tag);
    int cyc;
    cyc = 0;
    while (((gen_dut[0].done_cnt - base_done[0]) < 1 || (gen_dut[1].done_cnt - base_done[1]) < 1)
           && cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    check_eq({tag, "_timeout"}, (cyc < 5000) ? 1 : 0, 1);
    repeat (6) @(negedge clock);
    check_inst(tag, 0, gen_dut[0].busy_cnt - base_busy[0], gen_dut[0].done_cnt - base_done[0],
               gen_dut[0].rise_cnt - base_rise[0], gen_dut[0].viol_cnt, gen_dut[0].busy,
               gen_dut[0].latched);
    check_inst(tag, 1, gen_dut[1].busy_cnt - base_busy[1], gen_dut[1].done_cnt - base_done[1],
               gen_dut[1].rise_cnt - base_rise[1], gen_dut[1].viol_cnt, gen_dut[1].busy,
               gen_dut[1].latched);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_u0_busy"}, gen_dut[0].busy, 1'b0);
    check_eq({tag, "_u1_busy"}, gen_dut[1].busy, 1'b0);
    check_eq({tag, "_u0_sclk"}, gen_dut[0].sclk, 1'b0);
    check_eq({tag, "_u1_sclk"}, gen_dut[1].sclk, 1'b0);
    check_eq({tag, "_u0_load"}, gen_dut[0].sload, 1'b0);
    check_eq({tag, "_u1_load"}, gen_dut[1].sload, 1'b0);
    check_eq({tag, "_u0_done"}, gen_dut[0].done, 1'b0);
    check_eq({tag, "_u1_done"}, gen_dut[1].done, 1'b0);
    check_eq({tag, "_u0_srstn"}, gen_dut[0].srstn, 1'b0);
    check_eq({tag, "_u1_srstn"}, gen_dut[1].srstn, 1'b0);
  endtask

  initial begin
    logic [5:0]  a;
    logic [12:0] d;
    for (int k = 0; k < NUM_IO; k++) model[k] = DEF;

    // Reset state
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    for (int i = 0; i < 64; i++) check_read("rst_rd", 6'(i));
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_u0_srstn_rel", gen_dut[0].srstn, 1'b1);
    check_eq("rst_u1_srstn_rel", gen_dut[1].srstn, 1'b1);

    // Full load with two non-default words
    do_write(6'd37, 13'h1ABC, 1'b1);
    do_write(6'd0, 13'h0001, 1'b1);
    check_read("wr", 6'd37);
    check_read("wr", 6'd0);
    xfer_begin(1'b0, 6'd0, 13'd0);
    xfer_end("full");

    // Blocked write, ignored start and out-of-range write during a transfer
    xfer_begin(1'b0, 6'd0, 13'd0);
    repeat (400) @(negedge clock);
    do_write(6'd5, model[5] ^ 13'h1555, 1'b0);
    check_read("blk_wr", 6'd5);
    repeat (100) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    do_write(6'd40, 13'h1234, 1'b0);
    check_read("blk_oor", 6'd40);
    xfer_end("blocked");
    do_write(6'd40, 13'h0F0F, 1'b0);
    check_read("idle_oor", 6'd40);

    // Randomized config contents
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 12; i++) begin
        a = 6'($urandom_range(0, 63));
        d = 13'($urandom);
        do_write(a, d, a < NUM_IO);
      end
      for (int i = 0; i < 4; i++) check_read("rnd_rd", 6'($urandom_range(0, 63)));
      xfer_begin(1'b0, 6'd0, 13'd0);
      xfer_end($sformatf("rnd%0d", r));
    end

    // Reset in the middle of the shift (about bit 200 on the divide-by-4 instance)
    xfer_begin(1'b0, 6'd0, 13'd0);
    repeat (799) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int k = 0; k < NUM_IO; k++) model[k] = DEF;
    check_reset_outputs("midrst");
    check_read("midrst_rd", 6'd37);
    check_read("midrst_rd", 6'd0);
    check_read("midrst_rd", 6'd5);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    xfer_begin(1'b0, 6'd0, 13'd0);
    xfer_end("after_rst");

    // Start together with a write to the first-streamed pad
    xfer_begin(1'b1, 6'd37, 13'h1FFF);
    xfer_end("same_cycle");
    check_eq("same_cycle_u0_first13", gen_dut[0].latched[TOTAL-1 -: 13], 13'h1FFF);
    check_eq("same_cycle_u1_first13", gen_dut[1].latched[TOTAL-1 -: 13], 13'h1FFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
